// File: rtl/muldiv_ctrl_pkg.sv
// Shared types and constants for the RV32M multiply/divide sequencer.
package muldiv_ctrl_pkg;

  typedef enum logic [2:0] {
    F3_MUL    = 3'b000,
    F3_MULH   = 3'b001,
    F3_MULHSU = 3'b010,
    F3_MULHU  = 3'b011,
    F3_DIV    = 3'b100,
    F3_DIVU   = 3'b101,
    F3_REM    = 3'b110,
    F3_REMU   = 3'b111
  } muldiv_funct3_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } muldiv_state_t;

  localparam int          MULDIV_ITERS = 32;
  localparam logic [31:0] DIV0_QUOT    = 32'hFFFF_FFFF;

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Request/response bundle between the EX stage and the multiply/divide sequencer.
interface muldiv_ctrl_if
  import muldiv_ctrl_pkg::*;
#(
  parameter int XLEN = 32
);
  logic            start;
  muldiv_funct3_t  funct3;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, funct3, rs1_data, rs2_data, flush,
    input  busy, done, result
  );

  modport slave (
    input  start, funct3, rs1_data, rs2_data, flush,
    output busy, done, result
  );
endinterface

// File: rtl/muldiv_ctrl_iter.sv
// One combinational iteration: shift-add for multiply, restoring shift-subtract for divide.
// Latency 0 (pure combinational); no backpressure, the caller decides when to register acc_nxt.
module muldiv_ctrl_iter
  import muldiv_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              is_div,
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   operand,
  output logic [2*XLEN-1:0] acc_nxt
);
  logic [XLEN:0] mul_sum;
  logic [XLEN:0] div_diff;

  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : '0);
    // The shifted partial remainder can reach 33 bits for divisors above 2^31;
    // a negative trial result always shows up in bit XLEN of the difference.
    div_diff = acc[2*XLEN-1:XLEN-1] - {1'b0, operand};
    acc_nxt  = {mul_sum, acc[XLEN-1:1]};
    if (is_div) begin
      if (div_diff[XLEN]) begin
        acc_nxt = {acc[2*XLEN-2:0], 1'b0};
      end else begin
        acc_nxt = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      end
    end
  end
endmodule

// File: rtl/muldiv_ctrl.sv
// Iterative RV32M sequencer: 32 datapath steps plus sign fix-up; done pulse in cycle 34 (cycle 1 for special cases).
// No queueing: start is only sampled in IDLE, busy stalls the requester, flush aborts without a done pulse.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic         clk,
  input  logic         rst,
  muldiv_ctrl_if.slave bus
);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_t     state, state_nxt;
  muldiv_funct3_t    op_q;
  logic              neg_a_q, neg_b_q;
  logic [XLEN-1:0]   opnd_q;
  logic [XLEN-1:0]   result_q;
  logic [2*XLEN-1:0] acc_q, acc_nxt;
  logic [CNT_W-1:0]  cnt_q;

  logic [2:0]        f3;
  logic              sgn_a, sgn_b, neg_a, neg_b, is_div, div0, ovf, special, accept;
  logic [XLEN-1:0]   mag_a, mag_b, special_res;

  assign f3      = bus.funct3;
  assign is_div  = f3[2];
  assign sgn_a   = bus.funct3 inside {F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
  assign sgn_b   = bus.funct3 inside {F3_MULH, F3_DIV, F3_REM};
  assign neg_a   = sgn_a & bus.rs1_data[XLEN-1];
  assign neg_b   = sgn_b & bus.rs2_data[XLEN-1];
  // INT_MIN negates to itself, which is its correct unsigned magnitude
  assign mag_a   = neg_a ? -bus.rs1_data : bus.rs1_data;
  assign mag_b   = neg_b ? -bus.rs2_data : bus.rs2_data;
  assign div0    = is_div && (bus.rs2_data == '0);
  assign ovf     = (bus.funct3 == F3_DIV || bus.funct3 == F3_REM) &&
                   (bus.rs1_data == INT_MIN) && (bus.rs2_data == '1);
  assign special = div0 || ovf;
  assign special_res = div0 ? (f3[1] ? bus.rs1_data : DIV0_QUOT)
                            : (f3[1] ? '0 : INT_MIN);
  assign accept  = (state == IDLE) && bus.start && !bus.flush;

  muldiv_ctrl_iter #(.XLEN(XLEN)) u_iter (
    .is_div  (op_q[2]),
    .acc     (acc_q),
    .operand (opnd_q),
    .acc_nxt (acc_nxt)
  );

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix, fix_res;

  always_comb begin
    prod_fix = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
    quot_fix = (neg_a_q ^ neg_b_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_fix  = neg_a_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    case (op_q)
      F3_MUL:                       fix_res = prod_fix[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: fix_res = prod_fix[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              fix_res = quot_fix;
      default:                      fix_res = rem_fix;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    bus.busy  = (state != IDLE);
    bus.done  = 1'b0;
    case (state)
      IDLE: if (accept) state_nxt = special ? DONE : CALC;
      CALC: begin
        if (bus.flush) begin
          state_nxt = IDLE;
        end else if (cnt_q == CNT_W'(MULDIV_ITERS - 1)) begin
          state_nxt = FIX;
        end
      end
      FIX:  state_nxt = bus.flush ? IDLE : DONE;
      DONE: begin
        state_nxt = IDLE;
        bus.done  = !bus.flush;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      op_q     <= F3_MUL;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q    <= bus.funct3;
            neg_a_q <= neg_a;
            neg_b_q <= neg_b;
            cnt_q   <= '0;
            // Divide keeps the dividend in the low half; multiply keeps the multiplier there.
            if (is_div) begin
              acc_q  <= {{XLEN{1'b0}}, mag_a};
              opnd_q <= mag_b;
            end else begin
              acc_q  <= {{XLEN{1'b0}}, mag_b};
              opnd_q <= mag_a;
            end
            if (special) result_q <= special_res;
          end
        end
        CALC: begin
          acc_q <= acc_nxt;
          cnt_q <= cnt_q + CNT_W'(1);
        end
        FIX: if (!bus.flush) result_q <= fix_res;
        default: ;
      endcase
    end
  end

  assign bus.result = result_q;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: reference results queued at issue, compared on each done pulse.
module tb_muldiv_ctrl;
  import muldiv_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  muldiv_ctrl_if bus ();

  muldiv_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  typedef struct {
    muldiv_funct3_t f;
    logic [31:0]    a;
    logic [31:0]    b;
    int             poke;
  } op_t;
  op_t ops[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(muldiv_funct3_t f, logic [31:0] a, logic [31:0] b);
    logic signed [63:0] sa, sb;
    logic [63:0] ua, ub, p;
    logic [31:0] r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    p  = '0;
    r  = '0;
    case (f)
      F3_MUL:    begin p = ua * ub;          r = p[31:0];  end
      F3_MULH:   begin p = sa * sb;          r = p[63:32]; end
      F3_MULHSU: begin p = sa * $signed(ub); r = p[63:32]; end
      F3_MULHU:  begin p = ua * ub;          r = p[63:32]; end
      F3_DIV: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
        else begin p = sa / sb; r = p[31:0]; end
      end
      F3_REM: begin
        if (b == 0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
        else begin p = sa % sb; r = p[31:0]; end
      end
      F3_DIVU: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int exp_lat(muldiv_funct3_t f, logic [31:0] a, logic [31:0] b);
    logic [2:0] fb;
    fb = f;
    if (fb[2] && (b == 0 || (!fb[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
    return 34;
  endfunction

  // Drives a request at the current (negedge) time; accepted on the next rising edge.
  task automatic issue(input muldiv_funct3_t f, input logic [31:0] a, input logic [31:0] b,
                       input bit expect_done);
    bus.start    = 1'b1;
    bus.funct3   = f;
    bus.rs1_data = a;
    bus.rs2_data = b;
    if (expect_done) begin
      exp_q.push_back(ref_result(f, a, b));
      tag_q.push_back($sformatf("res_%s_%08h_%08h", f.name(), a, b));
    end
  endtask

  task automatic wait_done(input string tag, input int lat, input int poke);
    bit seen = 0;
    for (int n = 1; n <= 64 && !seen; n++) begin
      @(negedge clk);
      check({tag, "_busy"}, 32'(bus.busy), 32'd1);
      if (n == 1) begin
        bus.start    = 1'b0;
        bus.rs1_data = $urandom;
        bus.rs2_data = $urandom;
      end
      if (poke != 0 && n == poke) begin
        bus.start    = 1'b1;
        bus.funct3   = F3_DIVU;
        bus.rs1_data = $urandom;
        bus.rs2_data = $urandom_range(1, 9);
      end
      if (poke != 0 && n == poke + 1) bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        seen = 1;
        check({tag, "_lat"}, 32'(n), 32'(lat));
      end
    end
    if (!seen) check({tag, "_timeout"}, 32'd0, 32'd1);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    check({tag, "_idle"}, 32'(bus.busy), 32'd0);
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1 && bus.done === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
      else check(tag_q.pop_front(), bus.result, exp_q.pop_front());
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    bus.start    = 1'b0;
    bus.funct3   = F3_MUL;
    bus.rs1_data = '0;
    bus.rs2_data = '0;
    bus.flush    = 1'b0;
    rst          = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_result", bus.result, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    ops.push_back('{F3_MUL,    32'd7,          32'hFFFF_FFFD, 5});
    ops.push_back('{F3_MULH,   32'h8000_0000,  32'h8000_0000, 0});
    ops.push_back('{F3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 0});
    ops.push_back('{F3_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 0});
    ops.push_back('{F3_DIV,    32'hFFFF_FFF9,  32'd2,         0});
    ops.push_back('{F3_REM,    32'hFFFF_FFF9,  32'd2,         0});
    ops.push_back('{F3_DIVU,   32'd100,        32'd7,         0});
    ops.push_back('{F3_REMU,   32'd100,        32'd7,         0});
    ops.push_back('{F3_DIV,    32'd5,          32'd0,         0});
    ops.push_back('{F3_REM,    32'd5,          32'd0,         0});
    ops.push_back('{F3_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 0});
    ops.push_back('{F3_REM,    32'h8000_0000,  32'hFFFF_FFFF, 0});
    ops.push_back('{F3_DIVU,   32'hFFFF_FFFF,  32'h8000_0001, 0});
    ops.push_back('{F3_REMU,   32'hFFFF_FFFF,  32'h8000_0001, 0});
    ops.push_back('{F3_DIVU,   32'h8000_0000,  32'hFFFF_FFFF, 0});
    ops.push_back('{F3_REM,    32'h8000_0000,  32'd3,         0});
    for (int i = 0; i < 12; i++) begin
      op_t o;
      o.f    = muldiv_funct3_t'($urandom_range(0, 7));
      o.a    = $urandom;
      o.b    = (i % 4 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      o.poke = 0;
      ops.push_back(o);
    end

    foreach (ops[i]) begin
      issue(ops[i].f, ops[i].a, ops[i].b, 1'b1);
      wait_done($sformatf("op%0d_%s", i, ops[i].f.name()), exp_lat(ops[i].f, ops[i].a, ops[i].b),
                ops[i].poke);
    end

    // start together with flush in IDLE must be dropped
    bus.flush = 1'b1;
    issue(F3_MUL, 32'd1, 32'd1, 1'b0);
    @(negedge clk);
    check("flush_start_busy", 32'(bus.busy), 32'd0);
    bus.start = 1'b0;
    bus.flush = 1'b0;

    // flush in cycle 10 of a divide, then a new request in cycle 11
    issue(F3_DIV, 32'd1000, 32'd7, 1'b0);
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (n == 1) bus.start = 1'b0;
      check("flush_pre_busy", 32'(bus.busy), 32'd1);
    end
    bus.flush = 1'b1;
    @(negedge clk);
    check("flush_idle", 32'(bus.busy), 32'd0);
    check("flush_no_done", 32'(bus.done), 32'd0);
    bus.flush = 1'b0;
    issue(F3_DIVU, 32'd100, 32'd7, 1'b1);
    wait_done("after_flush", 34, 0);

    // reset in cycle 20 of a mulhu
    issue(F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 1) bus.start = 1'b0;
    end
    rst = 1'b0;
    @(negedge clk);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    check("midrst_result", bus.result, 32'd0);
    rst = 1'b1;
    issue(F3_MUL, 32'd3, 32'd4, 1'b1);
    wait_done("mul_after_rst", 34, 0);

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
Iterative sequencer for the RV32M multiply/divide unit. It sits beside the EX-stage ALU and accepts one M-extension operation (decoded by muldiv_funct3_t) at a time. It holds busy so the pipeline stalls, and returns a 32-bit result with a one-cycle done pulse. It runs a shared shift-add / restoring-subtract datapath for 32 iterations, with sign pre/post-correction and early-out for RISC-V special cases.

Parameters:
XLEN, 32, operand/result width; only 32 is supported.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-low reset; sampled on clk rising edge
start  in  1  request; sampled only in IDLE
funct3  in  3  muldiv_funct3_t op (mul, mulh, mulhsu, mulhu, div, divu, rem, remu)
rs1_data  in  32  operand A / dividend
rs2_data  in  32  operand B / divisor
flush  in  1  abort in-flight op (branch mispredict/trap)
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse; result valid only this cycle
result  out  32  registered result; holds last value otherwise

Behaviour:
- Reset (rst==0 at a clock edge):
  - state=IDLE; busy=0, done=0, result=0; counter, accumulators and latched operands cleared.
  - Reset overrides start and flush in the same cycle, and aborts any op in progress.
- IDLE:
  - start=1 latches funct3, rs1_data and rs2_data; later operand changes are ignored.
  - Records sign flags. Signed: mulh (both), mulhsu (rs1 only), div/rem (both). Unsigned: mul, mulhu, divu, remu.
  - Loads magnitudes, clears counter, then takes one of these transitions:
    - div/divu/rem/remu with rs2==0 -> DONE. Result: div/divu = 0xFFFFFFFF; rem/remu = rs1.
    - div/rem with rs1==0x80000000 and rs2==0xFFFFFFFF -> DONE. Result: div = 0x80000000; rem = 0.
    - otherwise -> CALC.
- CALC: one iteration per cycle, counter 0..31; at counter==31 -> FIX.
  - Multiply: 64-bit product register; add the shifted multiplicand when the current multiplier LSB is 1, then shift right.
  - Divide: 64-bit remainder/quotient register; shift left, trial-subtract divisor, keep the result if non-negative and set quotient bit 1, else restore.
- FIX: one cycle -> DONE. Applies sign correction and selects the result.
  - Product negated (64-bit two's complement) if the effective operand signs differ.
  - Quotient negated if dividend and divisor signs differ; remainder takes the dividend's sign.
  - Result select: mul = prod[31:0]; mulh/mulhsu/mulhu = prod[63:32]; div/divu = quotient; rem/remu = remainder.
- DONE: done=1 and result valid for exactly one cycle -> IDLE. busy=1 in DONE and deasserts the following cycle.
- Latency from start accepted at edge 0:
  - normal op: CALC covers cycles 1–32, FIX is cycle 33, done is high in cycle 34.
  - special case: done is high in cycle 1.
  - a new start is accepted in the cycle after done (back-to-back throughput 35 cycles).
- Start while busy is ignored; no queueing, and the requester must hold start until busy is seen.
- flush in CALC, FIX or DONE: next state IDLE and done forced to 0 that cycle. result is not updated.
- flush and start together in IDLE: start is ignored.
- Arithmetic widths:
  - All internal adders are 33 bits for divide and 64 bits for the product; no truncation before FIX.
  - Magnitude of 0x80000000 is 0x80000000, treated as unsigned 32-bit.

Decomposition:
- The rv32i_types package gains:
  - muldiv_state_t enum {IDLE, CALC, FIX, DONE}
  - constants MULDIV_ITERS=32 and DIV0_QUOT=32'hFFFFFFFF
- muldiv_funct3_t is reused unchanged.
- One sub-module, muldiv_iter: the combinational single-step datapath (add/shift for multiply, subtract/restore for divide). The FSM, counter and sign logic stay in muldiv_ctrl.

Test Plan:
- mul rs1=7, rs2=0xFFFFFFFD -> result 0xFFFFFFEB; busy cycles 1–34, done only in cycle 34.
- mulh 0x80000000×0x80000000 -> 0x40000000; mulhu 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE; mulhsu 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF.
- div 0xFFFFFFF9/2 -> 0xFFFFFFFD; rem -> 0xFFFFFFFF; divu 100/7 -> 14; remu -> 2.
- Special cases, each with done in cycle 1: div 5/0 -> 0xFFFFFFFF; rem 5/0 -> 5; div 0x80000000/0xFFFFFFFF -> 0x80000000; rem same operands -> 0.
- Flush, start-while-busy and back-to-back:
  - flush asserted in cycle 10 of a div -> no done pulse, busy=0 in cycle 11.
  - start during busy, with different operands -> ignored; result still reflects the first op.
  - new start in cycle 11 -> correct result.
- Reset mid-op:
  - rst=0 in cycle 20 of a mulhu -> busy=0, done=0, result=0 next cycle.
  - after release, mul 3×4 -> result 12 at cycle 34.
